// File: rtl/bit_pattern_pkg.sv
// -----------------------------------------------------------------------------
// bit_pattern_pkg
// Shared types and helpers for the bit_pattern_tx frame generator.
//   state_e       : FSM states (IDLE, SHIFT)
//   DEFAULT_WIDTH : default frame length in bits
//   calc_cw()     : count width able to hold 0..width
//   clamp_count() : limits a requested ones-count to the frame length
// -----------------------------------------------------------------------------
package bit_pattern_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Smallest count width that can represent every value 0..width.
  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

  // A frame cannot hold more ones than it has bits.
  function automatic int clamp_count(input int count, input int width);
    return (count > width) ? width : count;
  endfunction

endpackage

// File: rtl/bit_pattern_core.sv
// -----------------------------------------------------------------------------
// bit_pattern_core
// Combinational pattern rule: decides whether a frame bit is a 1.
// Build option: SPREAD_EN
//   undefined : thermometer pattern, bit = (idx < cnt); ports cnt_i, idx_i
//   defined   : evenly spread ones via an accumulator; ports cnt_i, acc_i,
//               acc_next_o (acc_i is the accumulator before this bit)
// Ports
//   cnt_i      : clamped ones-count of the frame (<= WIDTH)
//   idx_i      : bit index within the frame (thermometer build only)
//   acc_i      : accumulator entering this bit (spread build only)
//   acc_next_o : accumulator after this bit (spread build only)
//   bit_o      : frame bit value
// -----------------------------------------------------------------------------
module bit_pattern_core #(
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int IW    = 3
) (
`ifdef SPREAD_EN
  input  logic [CW:0]   acc_i,
  output logic [CW:0]   acc_next_o,
`else
  input  logic [IW-1:0] idx_i,
`endif
  input  logic [CW-1:0] cnt_i,
  output logic          bit_o
);

`ifdef SPREAD_EN
  logic [CW:0] acc_sum;

  // acc < WIDTH and cnt <= WIDTH, so the sum stays below 2*WIDTH and fits
  // in CW+1 bits; one subtraction is enough to wrap it back into range.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    bit_o      = 1'b0;
    acc_sum    = acc_i + {1'b0, cnt_i};
    acc_next_o = acc_sum;
    if (acc_sum >= (CW+1)'(WIDTH)) begin
      bit_o      = 1'b1;
      acc_next_o = acc_sum - (CW+1)'(WIDTH);
    end
  end
`else
  assign bit_o = (CW'(idx_i) < cnt_i);
`endif

endmodule

// File: rtl/bit_pattern_tx.sv
// -----------------------------------------------------------------------------
// bit_pattern_tx
// Emits a WIDTH-bit frame containing exactly the requested number of ones,
// serially (index 0 first, one bit per clk) and as a registered parallel word.
// Build option: SPREAD_EN selects the evenly spread pattern instead of the
// default thermometer pattern (see bit_pattern_core).
// Ports
//   clk         : rising-edge clock
//   reset       : synchronous, active-high reset
//   in_valid    : request present (held until accepted)
//   in_count    : requested number of ones
//   in_ready    : request can be accepted this cycle
//   bit_out     : serial frame bit
//   bit_valid   : bit_out meaningful
//   frame_start : high with bit index 0
//   frame_end   : high with bit index WIDTH-1
//   word_out    : parallel frame of the last accepted request
//   sat         : accepted count exceeded WIDTH (pulses with frame_start)
// -----------------------------------------------------------------------------
module bit_pattern_tx
  import bit_pattern_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [CW-1:0]    in_count,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic [WIDTH-1:0] word_out,
  output logic             sat
);

  localparam int            IW   = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_e             state_q;
  logic [IW-1:0]      idx_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   word_q;
  logic               bit_q;
  logic               bit_valid_q;
  logic               frame_start_q;
  logic               frame_end_q;
  logic               sat_q;

  logic               accept;
  logic [CW-1:0]      cnt_new;
  logic               sat_new;
  logic [WIDTH-1:0]   word_new;
  logic [IW-1:0]      idx_nxt;
  logic               adv_bit;

  // Ready while idle, or on the last bit so the next frame follows with no gap.
  assign in_ready = ~reset & ((state_q == IDLE) | (idx_q == LAST));
  assign accept   = in_valid & in_ready;

  assign cnt_new  = CW'(clamp_count(int'(in_count), WIDTH));
  assign sat_new  = (int'(in_count) > WIDTH);
  assign idx_nxt  = idx_q + IW'(1);

`ifdef SPREAD_EN
  logic [CW:0] acc_q;
  logic [CW:0] adv_acc;
  logic [CW:0] acc_chain [WIDTH+1];

  assign acc_chain[0] = '0;

  // Unrolled copy of the serial rule so the whole frame is known at accept.
  for (genvar i = 0; i < WIDTH; i++) begin : g_word
    bit_pattern_core #(.WIDTH(WIDTH), .CW(CW), .IW(IW)) u_word_bit (
      .acc_i      (acc_chain[i]),
      .acc_next_o (acc_chain[i+1]),
      .cnt_i      (cnt_new),
      .bit_o      (word_new[i])
    );
  end

  // Serial path: next bit from the accumulator left by the current bit.
  bit_pattern_core #(.WIDTH(WIDTH), .CW(CW), .IW(IW)) u_adv (
    .acc_i      (acc_q),
    .acc_next_o (adv_acc),
    .cnt_i      (cnt_q),
    .bit_o      (adv_bit)
  );

  // cnt*WIDTH is added over the frame and cnt*WIDTH is removed by the ones,
  // so the accumulator always ends the frame at zero.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      assert (acc_chain[WIDTH] == '0);
    end
  end
`else
  for (genvar i = 0; i < WIDTH; i++) begin : g_word
    bit_pattern_core #(.WIDTH(WIDTH), .CW(CW), .IW(IW)) u_word_bit (
      .idx_i (IW'(i)),
      .cnt_i (cnt_new),
      .bit_o (word_new[i])
    );
  end

  bit_pattern_core #(.WIDTH(WIDTH), .CW(CW), .IW(IW)) u_adv (
    .idx_i (idx_nxt),
    .cnt_i (cnt_q),
    .bit_o (adv_bit)
  );
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      word_q        <= '0;
      bit_q         <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      sat_q         <= 1'b0;
`ifdef SPREAD_EN
      acc_q         <= '0;
`endif
    end else begin
      frame_start_q <= 1'b0;
      sat_q         <= 1'b0;
      if (accept) begin
        // Start a frame: bit 0 is presented right after this edge.
        state_q       <= SHIFT;
        idx_q         <= '0;
        cnt_q         <= cnt_new;
        word_q        <= word_new;
        bit_q         <= word_new[0];
        bit_valid_q   <= 1'b1;
        frame_start_q <= 1'b1;
        frame_end_q   <= 1'b0;
        sat_q         <= sat_new;
`ifdef SPREAD_EN
        acc_q         <= acc_chain[1];
`endif
      end else if (state_q == SHIFT && idx_q != LAST) begin
        idx_q       <= idx_nxt;
        bit_q       <= adv_bit;
        frame_end_q <= (idx_nxt == LAST);
`ifdef SPREAD_EN
        acc_q       <= adv_acc;
`endif
      end else begin
        // Idle, or last bit shown with no follow-on request.
        state_q     <= IDLE;
        idx_q       <= '0;
        bit_q       <= 1'b0;
        bit_valid_q <= 1'b0;
        frame_end_q <= 1'b0;
`ifdef SPREAD_EN
        acc_q       <= '0;
`endif
      end
    end
  end

  assign bit_out     = bit_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign word_out    = word_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_bit_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_bit_pattern_tx
// Self-checking bench for bit_pattern_tx (WIDTH=8, CW=4). Honours SPREAD_EN
// the same way as the design. Expected frames come from a closed-form model:
//   thermometer : bit i = (i < c)
//   spread      : bit i = floor((i+1)*c/W) > floor(i*c/W)
// -----------------------------------------------------------------------------
module tb_bit_pattern_tx;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [CW-1:0] in_count;
  logic          in_ready;
  logic          bit_out;
  logic          bit_valid;
  logic          frame_start;
  logic          frame_end;
  logic [W-1:0]  word_out;
  logic          sat;

  int checks = 0;
  int errors = 0;

  bit_pattern_tx #(.WIDTH(W), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_count    (in_count),
    .in_ready    (in_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .word_out    (word_out),
    .sat         (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_frame(input int count);
    logic [W-1:0] f;
    int c;
    c = (count > W) ? W : count;
    f = '0;
    for (int i = 0; i < W; i++) begin
`ifdef SPREAD_EN
      f[i] = (((i + 1) * c) / W) > ((i * c) / W);
`else
      f[i] = (i < c);
`endif
    end
    return f;
  endfunction

  function automatic int ones_of(input logic [W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready timeout got %b want 1", name, in_ready);
    end
  endtask

  // Called with bit 0 on the outputs; returns with the last bit on them.
  task automatic check_frame(input int count, input string name);
    logic [W-1:0] exp_f;
    logic [5:0]   obs;
    logic [5:0]   exp;
    exp_f = model_frame(count);
    for (int i = 0; i < W; i++) begin
      if (i > 0) tick();
      obs = {bit_valid, bit_out, frame_start, frame_end, sat, in_ready};
      exp = {1'b1, exp_f[i], (i == 0), (i == W - 1), (i == 0) && (count > W), (i == W - 1)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s idx%0d {valid,bit,start,end,sat,ready} got %b want %b",
                 name, i, obs, exp);
      end
    end
    checks++;
    if (word_out !== exp_f) begin
      errors++;
      $display("FAIL %s word_out got %h want %h", name, word_out, exp_f);
    end
  endtask

  task automatic send_req(input int count, input string name);
    in_count = count[CW-1:0];
    in_valid = 1'b1;
    wait_ready(name);
    tick();
    in_valid = 1'b0;
    check_frame(count, name);
  endtask

  task automatic check_idle(input string name);
    logic [5:0] obs;
    tick();
    obs = {bit_valid, bit_out, frame_start, frame_end, sat, in_ready};
    checks++;
    if (obs !== 6'b000001) begin
      errors++;
      $display("FAIL %s idle {valid,bit,start,end,sat,ready} got %b want 000001", name, obs);
    end
  endtask

  task automatic check_word(input logic [W-1:0] exp, input string name);
    checks++;
    if (word_out !== exp) begin
      errors++;
      $display("FAIL %s word_out got %h want %h", name, word_out, exp);
    end
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_count = '0;
    repeat (3) tick();
    obs = {bit_valid, bit_out, frame_start, frame_end, sat, in_ready, |word_out};
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_hold outputs got %b want 0000000", obs);
    end
    reset = 1'b0;
    #1;
    obs = {bit_valid, bit_out, frame_start, frame_end, sat, in_ready, |word_out};
    checks++;
    if (obs !== 7'b0000010) begin
      errors++;
      $display("FAIL reset_release outputs got %b want 0000010", obs);
    end
  endtask

  task automatic test_single();
    send_req(5, "single5");
`ifdef SPREAD_EN
    check_word(8'hDA, "single5_const");
`else
    check_word(8'h1F, "single5_const");
`endif
    check_idle("single5_after");
  endtask

  task automatic test_back_to_back();
    in_count = 4'd0;
    in_valid = 1'b1;
    wait_ready("b2b_first");
    tick();
    in_count = 4'd8;
    check_frame(0, "b2b_zero");
    tick();
    in_valid = 1'b0;
    check_frame(8, "b2b_full");
    check_idle("b2b_after");
  endtask

  task automatic test_sat();
    send_req(12, "sat12");
    check_word(8'hFF, "sat12_const");
    check_idle("sat12_after");
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] exp_f;
    logic [1:0]   obs;
    logic [7:0]   flags;
    exp_f    = model_frame(6);
    in_count = 4'd6;
    in_valid = 1'b1;
    wait_ready("midrst_req");
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      obs = {bit_valid, bit_out};
      checks++;
      if (obs !== {1'b1, exp_f[i]}) begin
        errors++;
        $display("FAIL midrst idx%0d {valid,bit} got %b want %b", i, obs, {1'b1, exp_f[i]});
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    flags = {bit_valid, bit_out, frame_start, frame_end, sat, in_ready, |word_out, 1'b0};
    checks++;
    if (flags !== 8'b00000100) begin
      errors++;
      $display("FAIL midrst_after {valid,bit,start,end,sat,ready,word,0} got %b want 00000100", flags);
    end
    for (int i = 0; i < 6; i++) check_idle("midrst_quiet");
    send_req(2, "midrst_new2");
`ifdef SPREAD_EN
    check_word(8'h88, "midrst_new2_const");
`else
    check_word(8'h03, "midrst_new2_const");
`endif
    check_idle("midrst_new2_after");
  endtask

  task automatic test_pattern();
    send_req(3, "pat3");
`ifdef SPREAD_EN
    check_word(8'hA4, "pat3_const");
    checks++;
    if (dut.acc_q !== '0) begin
      errors++;
      $display("FAIL pat3_acc_end got %0d want 0", dut.acc_q);
    end
`else
    check_word(8'h07, "pat3_const");
`endif
    send_req(4, "pat4");
`ifdef SPREAD_EN
    check_word(8'hAA, "pat4_const");
    checks++;
    if (dut.acc_q !== '0) begin
      errors++;
      $display("FAIL pat4_acc_end got %0d want 0", dut.acc_q);
    end
`else
    check_word(8'h0F, "pat4_const");
`endif
    check_idle("pat_after");
  endtask

  // word_out fed to a ones-counter must give back the requested count.
  task automatic test_loopback();
    for (int c = 0; c <= W; c++) begin
      send_req(c, "loop");
      checks++;
      if (ones_of(word_out) != c) begin
        errors++;
        $display("FAIL loop count%0d ones got %0d want %0d", c, ones_of(word_out), c);
      end
    end
    check_idle("loop_after");
  endtask

  task automatic test_random();
    int c;
    int gap;
    for (int n = 0; n < 30; n++) begin
      c = $urandom_range(0, 15);
      send_req(c, "rand");
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) check_idle("rand_gap");
    end
    check_idle("rand_after");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sat();
    test_reset_mid_frame();
    test_pattern();
    test_loopback();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
